// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: occupancy states and the
// default bubble (NOP) payload.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [31:0] NOP_VAL = 32'h0000_0000;

endpackage : pipe_pkg

// File: rtl/en_reg.sv
// Load-enabled register with asynchronous active-low clear to a parameterised value.
// Used for both the main and the skid entry of pipe_skid_reg.
module en_reg #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: sequential state is always written with <= so every flop samples
   // pre-edge values regardless of the order the simulator evaluates blocks.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         q <= RST_VAL;
      else if (en)
         q <= d;
   end

endmodule : en_reg

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (main + skid) with registered in_ready,
// synchronous flush and a saturating stall-cycle counter.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(NOP_VAL),
   parameter int               CNT_W      = 16
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] stall_cnt
);

   state_t           state, state_nxt;
   logic             accept, pop, stall;
   logic             main_en, skid_en;
   logic [WIDTH-1:0] main_d, main_q, skid_q;

   // Both handshake outputs decode only the state flops, so neither depends
   // combinationally on in_valid or out_ready.
   assign in_ready  = (state != ST_FULL);
   assign out_valid = (state != ST_EMPTY);
   assign out_data  = main_q;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;
   assign stall  = out_valid & ~out_ready;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         state <= ST_EMPTY;
      else
         state <= state_nxt;
   end

   // NOTE: every signal assigned here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      main_en   = 1'b0;
      main_d    = in_data;
      skid_en   = 1'b0;

      if (flush) begin
         state_nxt = ST_EMPTY;
         main_en   = 1'b1;
         main_d    = BUBBLE_VAL;
      end else begin
         unique case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state_nxt = ST_ONE;
                  main_en   = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && pop) begin
                  main_en = 1'b1;
               end else if (accept) begin
                  state_nxt = ST_FULL;
                  skid_en   = 1'b1;
               end else if (pop) begin
                  // Draining to EMPTY reloads the bubble so out_data is NOP while invalid.
                  state_nxt = ST_EMPTY;
                  main_en   = 1'b1;
                  main_d    = BUBBLE_VAL;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  state_nxt = ST_ONE;
                  main_en   = 1'b1;
                  main_d    = skid_q;
               end
            end
            default: begin
               state_nxt = ST_EMPTY;
               main_en   = 1'b1;
               main_d    = BUBBLE_VAL;
            end
         endcase
      end
   end

   en_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL (BUBBLE_VAL)
   ) u_main (
      .clk  (clk),
      .clrn (clrn),
      .en   (main_en),
      .d    (main_d),
      .q    (main_q)
   );

   // NOTE: the skid payload is a don't-care while empty, but it is still reset
   // so the post-reset state is fully defined and X-free in simulation.
   en_reg #(
      .WIDTH   (WIDTH),
      .RST_VAL ('0)
   ) u_skid (
      .clk  (clk),
      .clrn (clrn),
      .en   (skid_en),
      .d    (in_data),
      .q    (skid_q)
   );

   // Flush squashes entries only; the performance counter keeps running.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         stall_cnt <= '0;
      else if (cnt_clr)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule : pipe_skid_reg

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline register for the pipelined CPU. It sits between two stages and replaces the fixed 32-bit stall/clear register. It uses a valid/ready handshake and holds up to two entries (main plus skid), so the upstream `in_ready` is registered and has no combinational path from downstream `out_ready`. It also supports a synchronous flush for branch and interrupt squash, and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- `WIDTH`, 32: payload width in bits.
- `BUBBLE_VAL`, 0: value driven on `out_data` whenever `out_valid` is 0 (NOP encoding).
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `clrn`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream offers `in_data`.
- `in_ready`  out  1  block can accept; registered.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid entry.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_data`  out  WIDTH  registered payload, or `BUBBLE_VAL` when invalid.
- `flush`  in  1  synchronous squash of all held entries.
- `cnt_clr`  in  1  synchronous clear of `stall_cnt`.
- `stall_cnt`  out  CNT_W  count of cycles with `out_valid & !out_ready`.

## Operation
- `accept` = `in_valid & in_ready`; `pop` = `out_valid & out_ready`.
- States are EMPTY (no entry), ONE (main valid) and FULL (main and skid valid).
- In every state, if neither case below applies, the state and all data hold.
- EMPTY:
  - `accept`: main <= `in_data`, go to ONE.
- ONE:
  - `accept & pop`: main <= `in_data`, stay in ONE.
  - `accept & !pop`: skid <= `in_data`, go to FULL.
  - `!accept & pop`: go to EMPTY.
- FULL (`in_ready`=0, so no accept is possible):
  - `pop`: main <= skid, go to ONE.
- Output decode:
  - `in_ready` = (state != FULL).
  - `out_valid` = (state != EMPTY).
- `out_data` is driven from the main register. The main register is loaded with `BUBBLE_VAL` on every transition into EMPTY, so `out_data` = `BUBBLE_VAL` whenever invalid.
- Ordering is strict FIFO: the skid entry is never presented before the main entry.
- `flush`:
  - Highest priority: next state is EMPTY and main <= `BUBBLE_VAL`.
  - Any `accept` or `pop` in the same cycle is discarded.
  - Upstream must treat a beat offered during a flush cycle as squashed.
- `stall_cnt`:
  - Increments when `out_valid & !out_ready`.
  - Saturates at all-ones.
  - `cnt_clr` wins over increment.
  - `flush` does not clear it.
- Asynchronous reset gives:
  - state EMPTY, `in_ready`=1, `out_valid`=0;
  - `out_data`=`BUBBLE_VAL`, skid=0;
  - `stall_cnt`=0.
- Reset mid-transfer drops all entries; there is no recovery.

## Timing
- Latency is 1 cycle: an accept at edge N gives `out_valid`=1 after edge N.
- Sustained throughput is 1 beat/cycle with `out_ready` held high; the skid stays empty.
- A downstream stall in ONE with an upstream beat fills the skid. `in_ready` drops after that edge, so it is one cycle late by design.
- FULL to ONE takes one `pop`. `in_ready` rises the following cycle.
- All outputs are registered. No combinational path exists from any input to any output.
- `flush` takes effect at the next edge. In the following cycle `out_valid`=0 and `in_ready`=1.

## Structure
- Shared package `pipe_pkg` holds:
  - state localparams (`ST_EMPTY`=2'd0, `ST_ONE`=2'd1, `ST_FULL`=2'd2);
  - the default NOP constant 32'h0000_0000.
- Sub-module `en_reg`: `WIDTH` bits, asynchronous active-low clear, synchronous load enable, load value input.
  - Instantiated twice, once for main and once for skid.
  - For main, the load value is muxed between `in_data`, skid and `BUBBLE_VAL`.
- The state register, control logic and counter live in the top level.

## Test plan
- Reset then stream: hold `out_ready`=1 and send 0x11, 0x22, 0x33 on consecutive cycles. Expect `out_data` 0x11/0x22/0x33 one cycle later each, `in_ready` constant 1 and `stall_cnt`=0.
- Skid fill: reach ONE with 0xA1, then `out_ready`=0 and send 0xB2. Expect FULL, `in_ready`=0 next cycle and `out_data`=0xA1 held. Then `out_ready`=1 gives 0xA1, then 0xB2, then `out_valid`=0 with `out_data`=`BUBBLE_VAL`.
- Flush in FULL with `in_valid`=1 (0xCC) and `out_ready`=1. Next cycle expect `out_valid`=0, `out_data`=0, `in_ready`=1; 0xCC and the skid entry never appear.
- Stall counter: hold a valid entry with `out_ready`=0 for 5 cycles. Expect `stall_cnt`=5. Assert `cnt_clr` together with a stall and expect 0. With `CNT_W`=3, stall 10 cycles and expect 7.
- Async reset: pull `clrn` low mid-cycle while in FULL. `out_valid`, `stall_cnt` and `out_data` go to 0 without waiting for a clock edge, and `in_ready`=1.
- Random: drive random `in_valid`, `out_ready` and 5% `flush` against a scoreboard queue cleared on flush. Expect no loss, duplication or reordering, and `in_ready` never high in FULL.
